alu_ctrl_seq: RTL and testbench

//   Multi-cycle control sequencer; drives the ALU's func/operand-select side.

---
 rtl/alu_ctrl_seq_pkg.sv | 35 +++
 rtl/alu_ctrl_seq_if.sv | 27 ++
 rtl/alu_ctrl_seq_insn_decode.sv | 37 +++
 rtl/alu_ctrl_seq.sv | 107 ++++++++++
 tb/tb_alu_ctrl_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
// Shared types and encodings for the ALU control sequencer: FSM states,
// MIPS opcode/funct values, ALU func codes and the decoded-instruction bundle.
package alu_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // ALU func codes
  localparam logic [5:0] FUNC_PLUS  = 6'h20;
  localparam logic [5:0] FUNC_MINUS = 6'h22;

  typedef struct packed {
    logic [5:0]  func;
    logic        alu_src_b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Instruction handshake plus the decoded control bus toward the ALU/register file.
interface alu_ctrl_seq_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  func;
  logic        alu_src_b;
  logic [31:0] imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic        reg_write;
  logic        illegal;
  logic        busy;

  modport master (
    output instr, instr_valid,
    input  instr_ready, func, alu_src_b, imm, rs_addr, rt_addr, wr_addr,
           reg_write, illegal, busy
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, func, alu_src_b, imm, rs_addr, rt_addr, wr_addr,
           reg_write, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_seq_insn_decode.sv
// Combinational MIPS decode of add/addu/sub/subu/addi/addiu into ALU controls;
// zero latency, no handshake.
module alu_ctrl_seq_insn_decode
  import alu_ctrl_seq_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    dec           = '0;
    dec.rs        = instr[25:21];
    dec.rt        = instr[20:16];
    dec.imm       = {{16{instr[15]}}, instr[15:0]};
    dec.wr        = instr[15:11];
    dec.alu_src_b = 1'b0;
    dec.func      = 6'h00;
    dec.illegal   = 1'b0;
    // No overflow detection, so signed and unsigned forms decode identically
    if (opcode == OP_RTYPE && (funct == FN_ADD || funct == FN_ADDU)) begin
      dec.func = FUNC_PLUS;
    end else if (opcode == OP_RTYPE && (funct == FN_SUB || funct == FN_SUBU)) begin
      dec.func = FUNC_MINUS;
    end else if (opcode == OP_ADDI || opcode == OP_ADDIU) begin
      dec.func      = FUNC_PLUS;
      dec.alu_src_b = 1'b1;
      dec.wr        = instr[20:16];
    end else begin
      dec.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle ALU control sequencer: accept -> reg_write 3 cycles later, one instr per 4 cycles;
// instr_ready only in IDLE, so the source is stalled for the whole sequence.
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_ctrl_seq_if.slave bus
);
  state_t      state;
  state_t      state_nxt;
  logic [31:0] instr_q;
  dec_t        dec;
  logic        accept;
  logic [5:0]  func_q;
  logic        alu_src_b_q;
  logic [31:0] imm_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  wr_q;
  logic        illegal_q;
  logic        ready_c;
  logic        busy_c;
  logic        reg_write_c;

  alu_ctrl_seq_insn_decode u_decode (
    .instr (instr_q),
    .dec   (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ready_c     = 1'b0;
    busy_c      = 1'b1;
    reg_write_c = 1'b0;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        busy_c  = 1'b0;
        if (bus.instr_valid) begin
          accept    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.illegal) state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_IDLE;
        else             state_nxt = S_EXECUTE;
      end
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: begin
        // r0 is hardwired zero; suppress the strobe rather than write it
        reg_write_c = (wr_q != 5'd0);
        state_nxt   = S_IDLE;
      end
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      func_q      <= '0;
      alu_src_b_q <= 1'b0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wr_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (accept) begin
        instr_q   <= bus.instr;
        illegal_q <= 1'b0;
      end
      if (state == S_DECODE) begin
        func_q      <= dec.func;
        alu_src_b_q <= dec.alu_src_b;
        imm_q       <= dec.imm;
        rs_q        <= dec.rs;
        rt_q        <= dec.rt;
        wr_q        <= dec.wr;
        illegal_q   <= dec.illegal;
      end
      // Only func idles at zero; operand selects and addresses keep their last value
      if (state == S_WRITEBACK) func_q <= '0;
    end
  end

  assign bus.instr_ready = ready_c;
  assign bus.busy        = busy_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.func        = func_q;
  assign bus.alu_src_b   = alu_src_b_q;
  assign bus.imm         = imm_q;
  assign bus.rs_addr     = rs_q;
  assign bus.rt_addr     = rt_q;
  assign bus.wr_addr     = wr_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: halting instance runs the main sequence, a skipping
// instance covers the HALT_ON_ILLEGAL=0 path.
module tb_alu_ctrl_seq;
  localparam logic [5:0] PLUS  = 6'h20;
  localparam logic [5:0] MINUS = 6'h22;

  typedef struct {
    logic [5:0]  func;
    logic        src_b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        wr_en;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   wr_cnt_h = 0;
  int   wr_cnt_s = 0;
  int   exp_writes = 0;
  exp_t sbq[$];

  alu_ctrl_seq_if bus_h ();
  alu_ctrl_seq_if bus_s ();

  alu_ctrl_seq #(.HALT_ON_ILLEGAL(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
  alu_ctrl_seq #(.HALT_ON_ILLEGAL(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_h.reg_write === 1'b1) wr_cnt_h <= wr_cnt_h + 1;
    if (bus_s.reg_write === 1'b1) wr_cnt_s <= wr_cnt_s + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] f, input logic sb, input logic [31:0] im,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                              input logic we);
    exp_t e;
    e.func = f; e.src_b = sb; e.imm = im; e.rs = rs; e.rt = rt; e.wr = wr; e.wr_en = we;
    return e;
  endfunction

  // Called at a negedge with the halting DUT idle; leaves the bench at the
  // negedge of the following IDLE cycle.
  task automatic send(input logic [31:0] w, input exp_t e, input bit keep);
    exp_t x;
    bus_h.instr       = w;
    bus_h.instr_valid = 1'b1;
    chk("ready_idle", bus_h.instr_ready, 1);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus_h.instr = $urandom();
    chk("decode_rdy_busy_wr", {bus_h.instr_ready, bus_h.busy, bus_h.reg_write}, 3'b010);
    @(negedge clk);
    x = sbq.pop_front();
    chk("ex_func", bus_h.func, x.func);
    chk("ex_src_b", bus_h.alu_src_b, x.src_b);
    chk("ex_imm", bus_h.imm, x.imm);
    chk("ex_rs", bus_h.rs_addr, x.rs);
    chk("ex_rt", bus_h.rt_addr, x.rt);
    chk("ex_wr", bus_h.wr_addr, x.wr);
    chk("ex_reg_write", bus_h.reg_write, 0);
    @(negedge clk);
    chk("wb_reg_write", bus_h.reg_write, x.wr_en);
    chk("wb_func", bus_h.func, x.func);
    chk("wb_wr", bus_h.wr_addr, x.wr);
    if (x.wr_en) exp_writes++;
    @(negedge clk);
    chk("idle_rdy_busy_wr", {bus_h.instr_ready, bus_h.busy, bus_h.reg_write}, 3'b100);
    chk("idle_func", bus_h.func, 0);
    chk("idle_wr_hold", bus_h.wr_addr, x.wr);
    if (!keep) bus_h.instr_valid = 1'b0;
  endtask

  initial begin
    bus_h.instr = '0; bus_h.instr_valid = 1'b0;
    bus_s.instr = '0; bus_s.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_busy_wr", {bus_h.instr_ready, bus_h.busy, bus_h.reg_write}, 3'b100);
    chk("rst_func", bus_h.func, 0);
    chk("rst_imm", bus_h.imm, 0);
    chk("rst_addrs", {bus_h.rs_addr, bus_h.rt_addr, bus_h.wr_addr}, 0);
    chk("rst_src_b_illegal", {bus_h.alu_src_b, bus_h.illegal}, 0);
    rst = 1'b0;
    @(negedge clk);

    send(32'h00221820, mk(PLUS,  1'b0, 32'h00001820, 5'd1, 5'd2, 5'd3, 1'b1), 1'b0);
    @(negedge clk);
    send(32'h00A62022, mk(MINUS, 1'b0, 32'h00002022, 5'd5, 5'd6, 5'd4, 1'b1), 1'b1);
    send(32'h2027FFFF, mk(PLUS,  1'b1, 32'hFFFFFFFF, 5'd1, 5'd7, 5'd7, 1'b1), 1'b1);
    send(32'h20000005, mk(PLUS,  1'b1, 32'h00000005, 5'd0, 5'd0, 5'd0, 1'b0), 1'b0);
    @(negedge clk);
    send(32'h24430010, mk(PLUS,  1'b1, 32'h00000010, 5'd2, 5'd3, 5'd3, 1'b1), 1'b1);
    send(32'h00E81023, mk(MINUS, 1'b0, 32'h00001023, 5'd7, 5'd8, 5'd2, 1'b1), 1'b1);

    // Back-to-back with valid held, then reset during EXECUTE of the second
    send(32'h00221820, mk(PLUS,  1'b0, 32'h00001820, 5'd1, 5'd2, 5'd3, 1'b1), 1'b1);
    bus_h.instr = 32'h00A62022;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_ex_func", bus_h.func, MINUS);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rdy_busy_wr", {bus_h.instr_ready, bus_h.busy, bus_h.reg_write}, 3'b100);
    chk("abort_func", bus_h.func, 0);
    chk("abort_addrs", {bus_h.rs_addr, bus_h.rt_addr, bus_h.wr_addr}, 0);
    rst = 1'b0;
    bus_h.instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_no_write", bus_h.reg_write, 0);
    chk("abort_ready", bus_h.instr_ready, 1);

    // Illegal with halting: parks until reset even with valid held
    bus_h.instr = 32'hFC000000;
    bus_h.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("halt_illegal", bus_h.illegal, 1);
    chk("halt_func", bus_h.func, 0);
    for (int i = 0; i < 4; i++) begin
      chk("halt_rdy_busy_wr", {bus_h.instr_ready, bus_h.busy, bus_h.reg_write}, 3'b010);
      @(negedge clk);
    end
    rst = 1'b1;
    bus_h.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("halt_rst_illegal", bus_h.illegal, 0);
    chk("halt_rst_ready", bus_h.instr_ready, 1);

    // Illegal with skipping: back to IDLE, sticky flag until next accept
    bus_s.instr = 32'hFC000000;
    bus_s.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.instr_valid = 1'b0;
    chk("skip_busy", bus_s.busy, 1);
    @(negedge clk);
    chk("skip_rdy_busy_wr", {bus_s.instr_ready, bus_s.busy, bus_s.reg_write}, 3'b100);
    chk("skip_illegal", bus_s.illegal, 1);
    chk("skip_func", bus_s.func, 0);
    @(negedge clk);
    chk("skip_illegal_sticky", bus_s.illegal, 1);
    bus_s.instr = 32'h00221820;
    bus_s.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.instr_valid = 1'b0;
    chk("skip_illegal_clear", bus_s.illegal, 0);
    @(negedge clk);
    chk("skip_add_func", bus_s.func, PLUS);
    @(negedge clk);
    chk("skip_add_write", bus_s.reg_write, 1);
    repeat (2) @(negedge clk);

    chk("write_count_h", wr_cnt_h, exp_writes);
    chk("write_count_s", wr_cnt_s, 1);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
